// File: rtl/ym_write_seq.sv
// ym_write_seq: host-side write sequencer for the YM2151 register file.
// Buffers (addr, data) writes in a DEPTH-entry FIFO and replays each one as an
// address strobe (A0=0), a one-cycle gap, a data strobe (A0=1), then a
// BUSY_CYCLES-long busy window before the next entry may start.
// Optional build macro: YM_WRITE_SEQ_ADDR_CACHE_EN -- skips the address phase
// when an entry targets the same register as the last address actually issued.
module ym_write_seq #(
  parameter int DEPTH       = 4,
  parameter int BUSY_CYCLES = 64
) (
  input  logic                   phiM,
  input  logic                   IC,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_addr,
  input  logic [7:0]             req_data,
  output logic                   CS_b,
  output logic                   WR_b,
  output logic                   RD_b,
  output logic                   A0,
  output logic [7:0]             bus_d,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, BUSY} state_t;

  state_t          state;
  logic [7:0]      mem_addr [DEPTH];
  logic [7:0]      mem_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   cnt;
  logic [7:0]      cur_addr, cur_data;
  logic            push, pop;
  logic [7:0]      head_addr, head_data;
`ifdef YM_WRITE_SEQ_ADDR_CACHE_EN
  logic [7:0]      last_addr;
  logic            last_valid;
`endif

  // Full is judged on the registered count only; a same-cycle pop never frees a slot early.
  assign req_ready  = (count != (AW+1)'(DEPTH));
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head_addr  = mem_addr[rd_ptr];
  assign head_data  = mem_data[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);
  assign RD_b       = 1'b1;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge phiM) begin
    if (!IC && push) begin
      mem_addr[wr_ptr] <= req_addr;
      mem_data[wr_ptr] <= req_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge phiM) begin
    if (IC) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bus-phase sequencer: IDLE -> ADDR -> GAP -> DATA -> BUSY x BUSY_CYCLES -> IDLE.
  always_ff @(posedge phiM) begin
    if (IC) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_addr   <= 8'h00;
      cur_data   <= 8'h00;
`ifdef YM_WRITE_SEQ_ADDR_CACHE_EN
      last_addr  <= 8'h00;
      last_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (pop) begin
          cur_addr <= head_addr;
          cur_data <= head_data;
`ifdef YM_WRITE_SEQ_ADDR_CACHE_EN
          // Chip still has this register latched: go straight to the data phase.
          state <= (last_valid && head_addr == last_addr) ? DATA : ADDR;
`else
          state <= ADDR;
`endif
        end
        ADDR: begin
          state <= GAP;
`ifdef YM_WRITE_SEQ_ADDR_CACHE_EN
          last_addr  <= cur_addr;
          last_valid <= 1'b1;
`endif
        end
        GAP:  state <= DATA;
        DATA: begin
          state <= BUSY;
          cnt   <= CW'(BUSY_CYCLES - 1);
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus pins decode purely from registered state and the current-entry registers.
  always_comb begin
    CS_b  = 1'b1;
    WR_b  = 1'b1;
    A0    = 1'b0;
    bus_d = 8'h00;
    case (state)
      ADDR: begin CS_b = 1'b0; WR_b = 1'b0; bus_d = cur_addr; end
      GAP:  bus_d = cur_addr;
      DATA: begin CS_b = 1'b0; WR_b = 1'b0; A0 = 1'b1; bus_d = cur_data; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ym_write_seq.sv
// Directed bench for ym_write_seq (DEPTH=4, BUSY_CYCLES=64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ym_write_seq;

  logic       phiM = 1'b0;
  logic       IC = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       CS_b, WR_b, RD_b, A0;
  logic [7:0] bus_d;
  logic [2:0] fifo_count;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ym_write_seq #(.DEPTH(4), .BUSY_CYCLES(64)) dut (
    .phiM(phiM), .IC(IC), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .CS_b(CS_b), .WR_b(WR_b),
    .RD_b(RD_b), .A0(A0), .bus_d(bus_d), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 phiM = ~phiM;

  wire [11:0] bus = {CS_b, WR_b, RD_b, A0, bus_d};

  task automatic step();
    @(posedge phiM);
    #1;
    cyc++;
  endtask

  // Advance until the next strobe (CS_b low) or until max cycles elapse.
  task automatic wait_strobe(input int max, output logic ok, output logic a0, output logic [7:0] d);
    ok = 1'b0; a0 = 1'b0; d = 8'h00;
    for (int i = 0; i < max; i++) begin
      step();
      if (!CS_b) begin ok = 1'b1; a0 = A0; d = bus_d; return; end
    end
  endtask

  task automatic drain(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic test_reset();
    IC = 1'b1; req_valid = 1'b0;
    step(); step();
    IC = 1'b0;
    n_cmp++; if (bus !== 12'hE00) begin n_fail++; $display("FAIL rst_bus got %h exp e00", bus); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    step();
    n_cmp++; if (bus !== 12'hE00) begin n_fail++; $display("FAIL idle_bus got %h exp e00", bus); end
  endtask

  task automatic test_single();
    int k;
    int bad;
    req_valid = 1'b1; req_addr = 8'h1B; req_data = 8'hC0;
    step();
    req_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_queued got cnt=%0d busy=%b exp 1/1", fifo_count, busy); end
    step();
    n_cmp++; if (bus !== 12'h21B) begin n_fail++; $display("FAIL single_addr got %h exp 21b", bus); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_pop got %0d exp 0", fifo_count); end
    step();
    n_cmp++; if (bus !== 12'hE1B) begin n_fail++; $display("FAIL single_gap got %h exp e1b", bus); end
    step();
    n_cmp++; if (bus !== 12'h3C0) begin n_fail++; $display("FAIL single_data got %h exp 3c0", bus); end
    // 64 BUSY cycles follow, so busy is first seen low on the 65th edge.
    k = 0; bad = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (!CS_b) bad++;
      if (!busy) begin k = i; break; end
    end
    n_cmp++; if (k !== 65) begin n_fail++; $display("FAIL single_busy_len got %0d exp 65", k); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL single_extra_strobe got %0d exp 0", bad); end
  endtask

  task automatic test_fill();
    logic ok, a0;
    logic [7:0] d;
    int t, tprev;
    logic [7:0] ad [5];
    logic [7:0] da [5];
    for (int i = 0; i < 5; i++) begin ad[i] = 8'h11 + 8'(i); da[i] = 8'hA1 + 8'(i); end
    req_valid = 1'b1; req_addr = 8'h10; req_data = 8'hA0;
    step();
    req_valid = 1'b0;
    wait_strobe(10, ok, a0, d);
    n_cmp++; if (!ok || d !== 8'h10) begin n_fail++; $display("FAIL fill_p0 got ok=%b d=%h exp 1/10", ok, d); end
    step(); step(); step();  // GAP, DATA, now in BUSY
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = ad[i]; req_data = da[i];
      n_cmp++; if (req_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready%0d got %b exp %b", i, req_ready, (i < 4)); end
      step();
    end
    req_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", fifo_count); end
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(200, ok, a0, d);
      t = cyc;
      n_cmp++; if (!ok || a0 !== 1'b0 || d !== ad[i]) begin n_fail++; $display("FAIL fill_addr%0d got ok=%b a0=%b d=%h exp 1/0/%h", i, ok, a0, d, ad[i]); end
      if (i > 0) begin
        n_cmp++; if (t - tprev !== 68) begin n_fail++; $display("FAIL fill_space%0d got %0d exp 68", i, t - tprev); end
      end
      tprev = t;
      step(); step();
      n_cmp++; if (bus !== {4'b0011, da[i]}) begin n_fail++; $display("FAIL fill_data%0d got %h exp %h", i, bus, {4'b0011, da[i]}); end
    end
    wait_strobe(80, ok, a0, d);
    n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_dropped got strobe d=%h exp none", d); end
  endtask

  task automatic test_simul();
    logic ok, a0;
    logic [7:0] d;
    int tb_, tc;
    req_valid = 1'b1; req_addr = 8'h30; req_data = 8'h31;
    step();
    req_valid = 1'b0;
    wait_strobe(10, ok, a0, d);  // ADDR of A
    req_valid = 1'b1; req_addr = 8'h32; req_data = 8'h33;
    step();
    req_addr = 8'h34; req_data = 8'h35;
    step();
    req_valid = 1'b0;
    n_cmp++; if (bus !== 12'h331 || fifo_count !== 3'd2) begin n_fail++; $display("FAIL simul_setup got bus=%h cnt=%0d exp 331/2", bus, fifo_count); end
    for (int i = 0; i < 65; i++) step();  // now IDLE with two queued
    req_valid = 1'b1; req_addr = 8'h36; req_data = 8'h37;
    n_cmp++; if (req_ready !== 1'b1 || CS_b !== 1'b1) begin n_fail++; $display("FAIL simul_idle got ready=%b cs=%b exp 1/1", req_ready, CS_b); end
    step();
    req_valid = 1'b0;
    tb_ = cyc;
    n_cmp++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL simul_count got %0d exp 2", fifo_count); end
    n_cmp++; if (bus !== 12'h232) begin n_fail++; $display("FAIL simul_addr_b got %h exp 232", bus); end
    step(); step();
    n_cmp++; if (bus !== 12'h333) begin n_fail++; $display("FAIL simul_data_b got %h exp 333", bus); end
    wait_strobe(200, ok, a0, d);
    tc = cyc;
    n_cmp++; if (!ok || a0 !== 1'b0 || d !== 8'h34 || tc - tb_ !== 68) begin n_fail++; $display("FAIL simul_c got ok=%b a0=%b d=%h dt=%0d exp 1/0/34/68", ok, a0, d, tc - tb_); end
    step(); step();
    wait_strobe(200, ok, a0, d);
    n_cmp++; if (!ok || a0 !== 1'b0 || d !== 8'h36) begin n_fail++; $display("FAIL simul_d got ok=%b a0=%b d=%h exp 1/0/36", ok, a0, d); end
    drain(200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL simul_drain got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic ok, a0;
    logic [7:0] d;
    int ndata;
    req_valid = 1'b1; req_addr = 8'h40; req_data = 8'h41;
    step();
    req_addr = 8'h42; req_data = 8'h43;
    step();
    req_addr = 8'h44; req_data = 8'h45;
    step();
    req_valid = 1'b0;
    ndata = 0;
    for (int i = 0; i < 400; i++) begin
      if (!CS_b && A0) begin ndata++; if (ndata == 2) break; end
      step();
    end
    n_cmp++; if (ndata !== 2 || bus_d !== 8'h43) begin n_fail++; $display("FAIL rmid_reach got n=%0d d=%h exp 2/43", ndata, bus_d); end
    IC = 1'b1;
    step();
    IC = 1'b0;
    n_cmp++; if (bus !== 12'hE00) begin n_fail++; $display("FAIL rmid_bus got %h exp e00", bus); end
    n_cmp++; if (fifo_count !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_state got cnt=%0d busy=%b rdy=%b exp 0/0/1", fifo_count, busy, req_ready); end
    wait_strobe(150, ok, a0, d);
    n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet got strobe d=%h exp none", d); end
    IC = 1'b1; req_valid = 1'b1; req_addr = 8'h50; req_data = 8'h51;
    step();
    IC = 1'b0; req_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_push got cnt=%0d busy=%b exp 0/0", fifo_count, busy); end
    wait_strobe(10, ok, a0, d);
    n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL rst_push_quiet got strobe d=%h exp none", d); end
  endtask

`ifdef YM_WRITE_SEQ_ADDR_CACHE_EN
  task automatic test_cache();
    logic ok, a0;
    logic [7:0] d;
    int td1;
    req_valid = 1'b1; req_addr = 8'h08; req_data = 8'h01;
    step();
    req_valid = 1'b0;
    wait_strobe(10, ok, a0, d);
    n_cmp++; if (!ok || a0 !== 1'b0 || d !== 8'h08) begin n_fail++; $display("FAIL cache_first got ok=%b a0=%b d=%h exp 1/0/08", ok, a0, d); end
    step(); step();
    td1 = cyc;
    req_valid = 1'b1; req_addr = 8'h08; req_data = 8'h78;
    step();
    req_valid = 1'b0;
    wait_strobe(200, ok, a0, d);
    n_cmp++; if (!ok || a0 !== 1'b1 || d !== 8'h78) begin n_fail++; $display("FAIL cache_skip got ok=%b a0=%b d=%h exp 1/1/78", ok, a0, d); end
    n_cmp++; if (cyc - td1 !== 66) begin n_fail++; $display("FAIL cache_period got %0d exp 66", cyc - td1); end
    req_valid = 1'b1; req_addr = 8'h20; req_data = 8'h55;
    step();
    req_valid = 1'b0;
    wait_strobe(200, ok, a0, d);
    n_cmp++; if (!ok || a0 !== 1'b0 || d !== 8'h20) begin n_fail++; $display("FAIL cache_new got ok=%b a0=%b d=%h exp 1/0/20", ok, a0, d); end
    drain(200, ok);
    IC = 1'b1;
    step();
    IC = 1'b0;
    req_valid = 1'b1; req_addr = 8'h08; req_data = 8'h02;
    step();
    req_valid = 1'b0;
    wait_strobe(10, ok, a0, d);
    n_cmp++; if (!ok || a0 !== 1'b0 || d !== 8'h08) begin n_fail++; $display("FAIL cache_cleared got ok=%b a0=%b d=%h exp 1/0/08", ok, a0, d); end
    drain(200, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_reset_mid();
`ifdef YM_WRITE_SEQ_ADDR_CACHE_EN
    test_cache();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
